row_reduce_ctrl: RTL and testbench



---
 rtl/row_reduce_ctrl.sv | 260 ++++++++++++++++++++++++++
 tb/tb_row_reduce_ctrl.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/row_reduce_ctrl.sv
// row_reduce_ctrl: brings a stabilizer frame of num_qubit rows (literals plus a
// per-row phase vector) into row-reduced canonical form. Rows are loaded into a
// register file, reduced in place column by column (X pass then Z pass), and
// streamed out.
// Optional feature macro: ROW_REDUCE_IMAG_CHECK_EN enables the sticky imag_err
// flag raised by any elimination product carrying a +/-i factor.
module row_reduce_ctrl #(
    parameter int num_qubit  = 4,
    parameter int max_vector = 2**num_qubit
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [2*num_qubit-1:0] in_literals,
    input  logic [max_vector-1:0]  in_phase,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [2*num_qubit-1:0] out_literals,
    output logic [max_vector-1:0]  out_phase,
    output logic                   out_last,
    output logic                   busy,
    output logic                   imag_err
);

    localparam int LW = 2 * num_qubit;
    localparam int IW = (num_qubit > 1) ? $clog2(num_qubit) : 1;
    localparam int NW = $clog2(num_qubit + 1);
    localparam logic [IW-1:0] LAST = IW'(num_qubit - 1);
    localparam logic [NW-1:0] ROWS = NW'(num_qubit);

    typedef enum logic [2:0] {LOAD, XSCAN, SWAP, ELIM, ZSCAN, UNLOAD} state_e;

    state_e          state_q, state_d;
    logic [IW-1:0]   ld_cnt_q, ld_cnt_d;
    logic [IW-1:0]   ul_cnt_q, ul_cnt_d;
    logic [IW-1:0]   col_q, col_d;
    logic [IW-1:0]   r_q, r_d;
    logic [IW-1:0]   piv_q, piv_d;
    logic [IW-1:0]   t_q, t_d;
    logic [NW-1:0]   next_row_q, next_row_d;
    logic            pass_z_q, pass_z_d;

    logic [LW-1:0]          lit_q [num_qubit];
    logic [max_vector-1:0]  ph_q  [num_qubit];

    logic                   do_adv;
    logic [NW-1:0]          adv_row;
    logic [IW-1:0]          pr;
    logic [IW:0]            bsel;
    logic                   elim_hit;
    logic [LW-1:0]          prod_lit;
    logic [max_vector-1:0]  prod_ph;

    // Sum of per-qubit i-exponents of target*pivot; bit 1 decides the phase
    // flip, so an odd sum behaves as sum-1 (the stray +/-i is dropped).
    function automatic logic sign_flip(input logic [LW-1:0] a, input logic [LW-1:0] b);
        logic [1:0] s;
        s = '0;
        for (int q = 0; q < num_qubit; q++) begin
            case ({a[2*q+:2], b[2*q+:2]})
                4'b10_11, 4'b11_01, 4'b01_10: s = s + 2'd1;  // XY, YZ, ZX: +i
                4'b10_01, 4'b11_10, 4'b01_11: s = s + 2'd3;  // XZ, YX, ZY: -i
                default: ;
            endcase
        end
        return s[1];
    endfunction

    // Pivot row is always the one at next_row; the pivot bit is X (odd bit) or Z (even bit) of col.
    assign pr       = next_row_q[IW-1:0];
    assign bsel     = {col_q, ~pass_z_q};
    assign elim_hit = (state_q == ELIM) && (t_q != pr) && lit_q[t_q][bsel];
    assign prod_lit = lit_q[t_q] ^ lit_q[pr];
    assign prod_ph  = ph_q[t_q] ^ ph_q[pr] ^ {max_vector{sign_flip(lit_q[t_q], lit_q[pr])}};

    // State and control-counter registers.
    // NOTE: sequential state is written with non-blocking assignments so every
    // register samples the values from before this edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= LOAD;
            ld_cnt_q   <= '0;
            ul_cnt_q   <= '0;
            col_q      <= '0;
            r_q        <= '0;
            piv_q      <= '0;
            t_q        <= '0;
            next_row_q <= '0;
            pass_z_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            ld_cnt_q   <= ld_cnt_d;
            ul_cnt_q   <= ul_cnt_d;
            col_q      <= col_d;
            r_q        <= r_d;
            piv_q      <= piv_d;
            t_q        <= t_d;
            next_row_q <= next_row_d;
            pass_z_q   <= pass_z_d;
        end
    end

    // Next-state logic: load, scan for a pivot, swap it up, eliminate, unload.
    // NOTE: every signal gets a default first so no path leaves it unassigned
    // and no latch is inferred.
    always_comb begin
        state_d    = state_q;
        ld_cnt_d   = ld_cnt_q;
        ul_cnt_d   = ul_cnt_q;
        col_d      = col_q;
        r_d        = r_q;
        piv_d      = piv_q;
        t_d        = t_q;
        next_row_d = next_row_q;
        pass_z_d   = pass_z_q;
        do_adv     = 1'b0;
        adv_row    = next_row_q;

        case (state_q)
            LOAD: begin
                if (in_valid) begin
                    if (ld_cnt_q == LAST) begin
                        ld_cnt_d   = '0;
                        col_d      = '0;
                        pass_z_d   = 1'b0;
                        next_row_d = '0;
                        r_d        = '0;
                        state_d    = XSCAN;
                    end else begin
                        ld_cnt_d = ld_cnt_q + IW'(1);
                    end
                end
            end
            XSCAN, ZSCAN: begin
                if (lit_q[r_q][bsel]) begin
                    piv_d   = r_q;
                    state_d = SWAP;
                end else if (r_q == LAST) begin
                    do_adv = 1'b1;
                end else begin
                    r_d = r_q + IW'(1);
                end
            end
            SWAP: begin
                t_d     = '0;
                state_d = ELIM;
            end
            ELIM: begin
                if (t_q == LAST) begin
                    do_adv     = 1'b1;
                    adv_row    = next_row_q + NW'(1);
                    next_row_d = adv_row;
                end else begin
                    t_d = t_q + IW'(1);
                end
            end
            UNLOAD: begin
                if (out_ready) begin
                    if (ul_cnt_q == LAST) begin
                        ul_cnt_d = '0;
                        state_d  = LOAD;
                    end else begin
                        ul_cnt_d = ul_cnt_q + IW'(1);
                    end
                end
            end
            default: state_d = LOAD;
        endcase

        // Move to the next (col, pass) pair, or finish when rows or columns run out.
        if (do_adv) begin
            r_d = adv_row[IW-1:0];
            if (adv_row == ROWS) begin
                state_d = UNLOAD;
            end else if (!pass_z_q) begin
                pass_z_d = 1'b1;
                state_d  = ZSCAN;
            end else if (col_q == LAST) begin
                state_d = UNLOAD;
            end else begin
                col_d    = col_q + IW'(1);
                pass_z_d = 1'b0;
                state_d  = XSCAN;
            end
        end
    end

    // Row register file: capture on load, exchange on swap, multiply on elimination.
    // NOTE: the file is small and must read as zero after reset, so it is reset
    // like ordinary registers rather than treated as an uninitialised RAM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < num_qubit; i++) begin
                lit_q[i] <= '0;
                ph_q[i]  <= '0;
            end
        end else begin
            case (state_q)
                LOAD: begin
                    if (in_valid) begin
                        lit_q[ld_cnt_q] <= in_literals;
                        ph_q[ld_cnt_q]  <= in_phase;
                    end
                end
                SWAP: begin
                    lit_q[piv_q] <= lit_q[pr];
                    lit_q[pr]    <= lit_q[piv_q];
                    ph_q[piv_q]  <= ph_q[pr];
                    ph_q[pr]     <= ph_q[piv_q];
                end
                ELIM: begin
                    if (elim_hit) begin
                        lit_q[t_q] <= prod_lit;
                        ph_q[t_q]  <= prod_ph;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef ROW_REDUCE_IMAG_CHECK_EN
    logic imag_err_q;

    // A product is imaginary when an odd number of qubits anticommute.
    function automatic logic is_imag(input logic [LW-1:0] a, input logic [LW-1:0] b);
        logic odd;
        odd = 1'b0;
        for (int q = 0; q < num_qubit; q++) begin
            if ((a[2*q+:2] != 2'b00) && (b[2*q+:2] != 2'b00) && (a[2*q+:2] != b[2*q+:2]))
                odd = ~odd;
        end
        return odd;
    endfunction

    // Sticky imaginary flag, cleared when the block returns to LOAD.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            imag_err_q <= 1'b0;
        end else if (state_q == UNLOAD && state_d == LOAD) begin
            imag_err_q <= 1'b0;
        end else if (elim_hit && is_imag(lit_q[t_q], lit_q[pr])) begin
            imag_err_q <= 1'b1;
        end
    end

    assign imag_err = imag_err_q;
`else
    assign imag_err = 1'b0;
`endif

    assign in_ready     = (state_q == LOAD);
    assign busy         = (state_q != LOAD);
    assign out_valid    = (state_q == UNLOAD);
    assign out_literals = out_valid ? lit_q[ul_cnt_q] : '0;
    assign out_phase    = out_valid ? ph_q[ul_cnt_q] : '0;
    assign out_last     = out_valid && (ul_cnt_q == LAST);

endmodule

// File: tb/tb_row_reduce_ctrl.sv
// Testbench for row_reduce_ctrl: directed frame table, hand-written reset and
// stall sequences, and random frames checked against a Pauli-algebra model.
module tb_row_reduce_ctrl;

    localparam int NQ        = 4;
    localparam int MV        = 1 << NQ;
    localparam int LW        = 2 * NQ;
    localparam int RED_BOUND = 2 * NQ * (NQ + 1 + NQ);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          out_ready = 1'b0;
    logic [LW-1:0] in_literals = '0;
    logic [MV-1:0] in_phase = '0;
    logic          in_ready, out_valid, out_last, busy, imag_err;
    logic [LW-1:0] out_literals;
    logic [MV-1:0] out_phase;

    always #5 clk = ~clk;

    row_reduce_ctrl #(.num_qubit(NQ), .max_vector(MV)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_literals  (in_literals),
        .in_phase     (in_phase),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_literals (out_literals),
        .out_phase    (out_phase),
        .out_last     (out_last),
        .busy         (busy),
        .imag_err     (imag_err)
    );

    int vectors = 0;
    int miscompares = 0;

    logic [LW-1:0] cur_lit [NQ];
    logic [MV-1:0] cur_ph  [NQ];
    logic [LW-1:0] exp_lit [NQ];
    logic [MV-1:0] exp_ph  [NQ];
    logic          exp_imag;

    typedef struct packed {
        logic [NQ-1:0][LW-1:0] lit;
        logic [NQ-1:0][MV-1:0] ph;
        logic [NQ-1:0][LW-1:0] elit;
        logic [NQ-1:0][MV-1:0] eph;
        logic                  eimag;
        logic [3:0]            stall_row;
        logic [4:0]            stall_len;
    } vec_t;

    vec_t tbl [5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        vectors++;
        if (act !== expv) begin
            miscompares++;
            $display("FAIL %s: actual %0h required %0h at %0t", name, act, expv, $time);
        end
    endtask

    // Pauli string to literal vector; character q is qubit q.
    function automatic logic [LW-1:0] pl(input string s);
        logic [LW-1:0] v;
        byte c;
        v = '0;
        for (int q = 0; q < NQ; q++) begin
            c = s[q];
            case (c)
                "Z": v[2*q+:2] = 2'd1;
                "X": v[2*q+:2] = 2'd2;
                "Y": v[2*q+:2] = 2'd3;
                default: v[2*q+:2] = 2'd0;
            endcase
        end
        return v;
    endfunction

    // Exponent of i in the single-qubit product P1*P2 (x/z symplectic form).
    function automatic int gexp(input int x1, input int z1, input int x2, input int z2);
        if (x1 == 0 && z1 == 0) return 0;
        if (x1 == 1 && z1 == 1) return z2 - x2;
        if (x1 == 1) return z2 * (2 * x2 - 1);
        return x2 * (1 - 2 * z2);
    endfunction

    function automatic bit pbit(input logic [LW-1:0] l, input int col, input int zpass);
        return l[2*col + (zpass ? 0 : 1)];
    endfunction

    // Reference reduction: Gaussian elimination over (col, X then Z) with phase tracking.
    task automatic model_reduce();
        int nr, piv, s;
        logic [LW-1:0] tl;
        logic [MV-1:0] tp;
        for (int i = 0; i < NQ; i++) begin
            exp_lit[i] = cur_lit[i];
            exp_ph[i]  = cur_ph[i];
        end
        exp_imag = 1'b0;
        nr = 0;
        for (int col = 0; col < NQ; col++) begin
            for (int zp = 0; zp < 2; zp++) begin
                if (nr < NQ) begin
                    piv = -1;
                    for (int r = nr; r < NQ; r++)
                        if (piv < 0 && pbit(exp_lit[r], col, zp)) piv = r;
                    if (piv >= 0) begin
                        tl = exp_lit[piv]; exp_lit[piv] = exp_lit[nr]; exp_lit[nr] = tl;
                        tp = exp_ph[piv];  exp_ph[piv]  = exp_ph[nr];  exp_ph[nr]  = tp;
                        for (int t = 0; t < NQ; t++) begin
                            if (t != nr && pbit(exp_lit[t], col, zp)) begin
                                s = 0;
                                for (int q = 0; q < NQ; q++)
                                    s += gexp(int'(exp_lit[t][2*q+1]), int'(exp_lit[t][2*q]),
                                              int'(exp_lit[nr][2*q+1]), int'(exp_lit[nr][2*q]));
                                s = ((s % 4) + 4) % 4;
                                exp_lit[t] = exp_lit[t] ^ exp_lit[nr];
                                exp_ph[t]  = exp_ph[t] ^ exp_ph[nr] ^ ((s >= 2) ? {MV{1'b1}} : {MV{1'b0}});
                                if (s % 2 == 1) exp_imag = 1'b1;
                            end
                        end
                        nr++;
                    end
                end
            end
        end
    endtask

    task automatic load_rows();
        int guard;
        check("load_in_ready", {31'b0, in_ready}, 32'd1);
        check("load_busy_low", {31'b0, busy}, 32'd0);
        for (int i = 0; i < NQ; i++) begin
            repeat ($urandom_range(0, 2)) begin
                in_valid = 1'b0;
                @(posedge clk); #1;
            end
            in_valid    = 1'b1;
            in_literals = cur_lit[i];
            in_phase    = cur_ph[i];
            guard = 0;
            while (!in_ready && guard < 200) begin
                @(posedge clk); #1;
                guard++;
            end
            if (guard >= 200) check("load_ready_timeout", 32'd1, 32'd0);
            @(posedge clk); #1;
        end
        in_valid    = 1'b0;
        in_literals = LW'($urandom);
        in_phase    = MV'($urandom);
        check("busy_after_last_load", {31'b0, busy}, 32'd1);
    endtask

    task automatic wait_reduce();
        int cyc;
        cyc = 0;
        while (!out_valid && cyc < 4 * RED_BOUND) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("reduce_within_bound", {31'b0, (out_valid && cyc <= RED_BOUND)}, 32'd1);
    endtask

    task automatic unload_rows(input int stall_row, input int stall_len);
        int nst;
`ifdef ROW_REDUCE_IMAG_CHECK_EN
        check("imag_err", {31'b0, imag_err}, {31'b0, exp_imag});
`else
        check("imag_err_tied", {31'b0, imag_err}, 32'd0);
`endif
        for (int i = 0; i < NQ; i++) begin
            nst = (i == stall_row) ? stall_len : int'($urandom_range(0, 2));
            out_ready = 1'b0;
            repeat (nst) begin
                check("stall_valid", {31'b0, out_valid}, 32'd1);
                check("stall_lit", {24'b0, out_literals}, {24'b0, exp_lit[i]});
                check("stall_ph", {16'b0, out_phase}, {16'b0, exp_ph[i]});
                @(posedge clk); #1;
            end
            out_ready = 1'b1;
            check("out_valid", {31'b0, out_valid}, 32'd1);
            check("out_lit", {24'b0, out_literals}, {24'b0, exp_lit[i]});
            check("out_ph", {16'b0, out_phase}, {16'b0, exp_ph[i]});
            check("out_last", {31'b0, out_last}, {31'b0, (i == NQ - 1)});
            @(posedge clk); #1;
            out_ready = 1'b0;
        end
        check("ready_after_unload", {31'b0, in_ready}, 32'd1);
        check("valid_after_unload", {31'b0, out_valid}, 32'd0);
        check("imag_cleared", {31'b0, imag_err}, 32'd0);
    endtask

    task automatic set_row(input int k, input int i, input string li, input logic [MV-1:0] p,
                           input string lo, input logic [MV-1:0] ep);
        tbl[k].lit[i]  = pl(li);
        tbl[k].ph[i]   = p;
        tbl[k].elit[i] = pl(lo);
        tbl[k].eph[i]  = ep;
    endtask

    task automatic use_entry(input int k);
        for (int i = 0; i < NQ; i++) begin
            cur_lit[i] = tbl[k].lit[i];
            cur_ph[i]  = tbl[k].ph[i];
            exp_lit[i] = tbl[k].elit[i];
            exp_ph[i]  = tbl[k].eph[i];
        end
        exp_imag = tbl[k].eimag;
    endtask

    initial begin
        // Directed frames: input rows, expected reduced rows.
        set_row(0, 0, "XXII", 16'h0000, "XXII", 16'h0000);
        set_row(0, 1, "ZZII", 16'h0000, "ZZII", 16'h0000);
        set_row(0, 2, "IIXX", 16'h0000, "IIXX", 16'h0000);
        set_row(0, 3, "IIZZ", 16'h0000, "IIZZ", 16'h0000);
        tbl[0].eimag = 1'b0; tbl[0].stall_row = 4'hF; tbl[0].stall_len = 5'd0;
        set_row(1, 0, "XXII", 16'h0000, "XXII", 16'h0000);
        set_row(1, 1, "YYII", 16'h0F0F, "ZZII", 16'hF0F0);
        set_row(1, 2, "IIII", 16'h1234, "IIII", 16'h1234);
        set_row(1, 3, "IIII", 16'hABCD, "IIII", 16'hABCD);
        tbl[1].eimag = 1'b0; tbl[1].stall_row = 4'd1; tbl[1].stall_len = 5'd10;
        set_row(2, 0, "ZIII", 16'h0033, "XZII", 16'h0000);
        set_row(2, 1, "XZII", 16'h0000, "ZIII", 16'h0033);
        set_row(2, 2, "IIII", 16'h0000, "IIII", 16'h0000);
        set_row(2, 3, "IIII", 16'h0000, "IIII", 16'h0000);
        tbl[2].eimag = 1'b0; tbl[2].stall_row = 4'hF; tbl[2].stall_len = 5'd0;
        set_row(3, 0, "XIII", 16'h0000, "XIII", 16'h0000);
        set_row(3, 1, "YIII", 16'h00FF, "ZIII", 16'hFF00);
        set_row(3, 2, "IIII", 16'h0000, "IIII", 16'h0000);
        set_row(3, 3, "IIII", 16'h0000, "IIII", 16'h0000);
        tbl[3].eimag = 1'b1; tbl[3].stall_row = 4'hF; tbl[3].stall_len = 5'd0;
        set_row(4, 0, "ZIII", 16'h0000, "XXXX", 16'h8000);
        set_row(4, 1, "ZZII", 16'h0001, "ZIII", 16'h0000);
        set_row(4, 2, "XXXX", 16'h8000, "IZII", 16'h0001);
        set_row(4, 3, "IIII", 16'h0000, "IIII", 16'h0000);
        tbl[4].eimag = 1'b0; tbl[4].stall_row = 4'd3; tbl[4].stall_len = 5'd4;

        // Reset values while held in reset.
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", {31'b0, in_ready}, 32'd1);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_out_last", {31'b0, out_last}, 32'd0);
        check("rst_out_lit", {24'b0, out_literals}, 32'd0);
        check("rst_out_ph", {16'b0, out_phase}, 32'd0);
        check("rst_imag", {31'b0, imag_err}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Table-driven directed frames.
        for (int k = 0; k < 5; k++) begin
            use_entry(k);
            load_rows();
            wait_reduce();
            unload_rows(int'(tbl[k].stall_row), int'(tbl[k].stall_len));
        end

        // Asynchronous reset while the block is eliminating.
        use_entry(3);
        load_rows();
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_in_ready", {31'b0, in_ready}, 32'd1);
        check("midrst_busy", {31'b0, busy}, 32'd0);
        check("midrst_out_valid", {31'b0, out_valid}, 32'd0);
        check("midrst_out_lit", {24'b0, out_literals}, 32'd0);
        check("midrst_imag", {31'b0, imag_err}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        use_entry(4);
        load_rows();
        wait_reduce();
        unload_rows(-1, 0);

        // Random frames against the reference model.
        for (int f = 0; f < 30; f++) begin
            for (int i = 0; i < NQ; i++) begin
                cur_lit[i] = LW'($urandom);
                if ($urandom_range(0, 1) == 1) cur_lit[i] = cur_lit[i] & LW'($urandom);
                cur_ph[i] = MV'($urandom);
            end
            model_reduce();
            load_rows();
            wait_reduce();
            unload_rows(int'($urandom_range(0, NQ - 1)), int'($urandom_range(0, 5)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
